// File: rtl/image_downscaler.sv
// image_downscaler: crops a programmable window out of a raster pixel stream,
// reduces it by 2**STEP_LOG2 in both directions (point decimation or box
// average) and keeps the result in an internal frame buffer.
//
// Ports:
//   CLK, RST_N          pixel clock, asynchronous active-low reset
//   START, MODE         arm a new capture; MODE 0 = decimate, 1 = box average
//   PIX_VALID, X_CONT,
//   Y_CONT, PIX_DATA    source pixel stream (channel 0 in the MSBs)
//   RD_EN, RD_ADDR      buffer read request, address = row*OUT_W + col
//   RD_DATA, RD_VALID   registered read response, one cycle after RD_EN
//   BUSY, DONE          capture armed/in progress, complete frame held
module image_downscaler #(
    parameter int unsigned CH        = 3,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned OUT_W     = 20,
    parameter int unsigned OUT_H     = 20,
    parameter int unsigned STEP_LOG2 = 5,
    parameter int unsigned CROP_X0   = 160,
    parameter int unsigned CROP_Y0   = 0,
    parameter int unsigned COORD_W   = 16,
    parameter int unsigned ADDR_W    = $clog2(OUT_W*OUT_H)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   START,
    input  logic                   MODE,
    input  logic                   PIX_VALID,
    input  logic [COORD_W-1:0]     X_CONT,
    input  logic [COORD_W-1:0]     Y_CONT,
    input  logic [CH*DATA_W-1:0]   PIX_DATA,
    input  logic                   RD_EN,
    input  logic [ADDR_W-1:0]      RD_ADDR,
    output logic [CH*DATA_W-1:0]   RD_DATA,
    output logic                   RD_VALID,
    output logic                   BUSY,
    output logic                   DONE
);

    localparam int unsigned PIX_W = CH * DATA_W;
    localparam int unsigned STEP  = 1 << STEP_LOG2;
    localparam int unsigned WIN_W = OUT_W * STEP;
    localparam int unsigned WIN_H = OUT_H * STEP;
    localparam int unsigned DEPTH = OUT_W * OUT_H;
    localparam int unsigned ACC_W = DATA_W + 2 * STEP_LOG2;
    localparam int unsigned COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic   busy_q, done_q, busy_nxt, done_nxt;
    logic   mode_q;

    logic [COORD_W-1:0] dx, dy;
    logic [COORD_W-1:0] step_mask;
    logic               in_win, frame_start, take, proc;
    logic               blk_first, blk_last, is_last;
    logic [COL_W-1:0]   col;
    logic [31:0]        addr_full;
    logic [ADDR_W-1:0]  wr_addr;
    logic               wr_en;
    logic [PIX_W-1:0]   wr_data, avg_px;

    logic [ACC_W-1:0]   acc     [OUT_W][CH];
    logic [ACC_W-1:0]   acc_sum [CH];
    logic [PIX_W-1:0]   mem     [DEPTH];

    logic [PIX_W-1:0]   rd_data_q;
    logic               rd_valid_q;

    // Window decode: local offsets, block position and output address
    always_comb begin
        step_mask   = COORD_W'(STEP - 1);
        dx          = X_CONT - COORD_W'(CROP_X0);
        dy          = Y_CONT - COORD_W'(CROP_Y0);
        in_win      = (X_CONT >= COORD_W'(CROP_X0)) && (dx < COORD_W'(WIN_W)) &&
                      (Y_CONT >= COORD_W'(CROP_Y0)) && (dy < COORD_W'(WIN_H));
        frame_start = PIX_VALID && (X_CONT == '0) && (Y_CONT == '0);
        // START wins over pixel processing; ARMED only consumes the frame-start pixel
        take        = !START && PIX_VALID &&
                      ((state == S_CAPTURE) || ((state == S_ARMED) && frame_start));
        proc        = take && in_win;
        blk_first   = ((dx & step_mask) == '0) && ((dy & step_mask) == '0);
        blk_last    = ((dx & step_mask) == step_mask) && ((dy & step_mask) == step_mask);
        is_last     = proc && (dx == COORD_W'(WIN_W - 1)) && (dy == COORD_W'(WIN_H - 1));
        col         = COL_W'(dx >> STEP_LOG2);
        addr_full   = 32'(dy >> STEP_LOG2) * 32'(OUT_W) + 32'(dx >> STEP_LOG2);
        wr_addr     = ADDR_W'(addr_full);
    end

    // Per-channel running block sum and its truncated mean
    always_comb begin
        avg_px = '0;
        for (int unsigned c = 0; c < CH; c++) begin
            acc_sum[c] = acc[col][c] + ACC_W'(PIX_DATA[(CH-1-c)*DATA_W +: DATA_W]);
            avg_px[(CH-1-c)*DATA_W +: DATA_W] = DATA_W'(acc_sum[c] >> (2 * STEP_LOG2));
        end
    end

    always_comb begin
        wr_en   = proc && (mode_q ? blk_last : blk_first);
        wr_data = mode_q ? avg_px : PIX_DATA;
    end

    // State register and registered status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (START) begin
            state_nxt = S_ARMED;
        end else begin
            case (state)
                S_ARMED:   if (take) state_nxt = is_last ? S_DONE : S_CAPTURE;
                S_CAPTURE: if (is_last) state_nxt = S_DONE;
                default:   state_nxt = state;
            endcase
        end
    end

    // Status outputs follow the state being entered so they change with it
    always_comb begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        case (state_nxt)
            S_ARMED, S_CAPTURE: busy_nxt = 1'b1;
            S_DONE:             done_nxt = 1'b1;
            default: ;
        endcase
    end

    // Capture mode is held for the whole frame
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)     mode_q <= 1'b0;
        else if (START) mode_q <= MODE;
    end

    // Column accumulators: one block row in flight per column, cleared on completion
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < OUT_W; i++)
                for (int unsigned c = 0; c < CH; c++)
                    acc[i][c] <= '0;
        end else if (START) begin
            for (int unsigned i = 0; i < OUT_W; i++)
                for (int unsigned c = 0; c < CH; c++)
                    acc[i][c] <= '0;
        end else if (proc && mode_q) begin
            for (int unsigned c = 0; c < CH; c++)
                acc[col][c] <= blk_last ? '0 : acc_sum[c];
        end
    end

    // Frame buffer write port (contents not reset)
    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read port; out-of-range addresses return zero
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= RD_EN;
            if (RD_EN) rd_data_q <= (32'(RD_ADDR) < DEPTH) ? mem[RD_ADDR] : '0;
        end
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_image_downscaler.sv
// tb_image_downscaler: directed capture scenarios with randomized gaps and
// pixel data, checked against a frame-level reference model.
module tb_image_downscaler;

    localparam int unsigned CH = 3, DW = 8, OW = 4, OH = 3, SL = 2;
    localparam int unsigned X0 = 8, Y0 = 4, CW = 16, AW = 4;
    localparam int unsigned STEP = 1 << SL;
    localparam int FW = 32, FH = 20;
    localparam int X_LAST = X0 + OW * STEP - 1;
    localparam int Y_LAST = Y0 + OH * STEP - 1;

    logic            CLK = 1'b0;
    logic            RST_N, START, MODE, PIX_VALID, RD_EN;
    logic [CW-1:0]   X_CONT, Y_CONT;
    logic [23:0]     PIX_DATA;
    logic [AW-1:0]   RD_ADDR;
    logic [23:0]     RD_DATA;
    logic            RD_VALID, BUSY, DONE;

    image_downscaler #(
        .CH(CH), .DATA_W(DW), .OUT_W(OW), .OUT_H(OH), .STEP_LOG2(SL),
        .CROP_X0(X0), .CROP_Y0(Y0), .COORD_W(CW), .ADDR_W(AW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .MODE(MODE),
        .PIX_VALID(PIX_VALID), .X_CONT(X_CONT), .Y_CONT(Y_CONT),
        .PIX_DATA(PIX_DATA), .RD_EN(RD_EN), .RD_ADDR(RD_ADDR),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_rises = 0;
    logic        done_prev = 1'b0;
    logic [23:0] fr [FH][FW];
    logic [23:0] rd_d;
    logic        rd_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge CLK);
        #1;
        if (DONE && !done_prev) done_rises++;
        done_prev = DONE;
    endtask

    task automatic fill_pattern();
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++)
                fr[y][x] = {8'(x), 8'(y), 8'(x + y)};
    endtask

    task automatic fill_random();
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++)
                fr[y][x] = 24'($urandom);
    endtask

    // Expected buffer word from the whole source frame
    function automatic logic [23:0] model(input int addr, input bit avg);
        int          row, col, s;
        logic [23:0] p, r;
        r = '0;
        if (addr >= int'(OW * OH)) return r;
        row = addr / int'(OW);
        col = addr % int'(OW);
        if (!avg) return fr[int'(Y0) + row * int'(STEP)][int'(X0) + col * int'(STEP)];
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            for (int j = 0; j < int'(STEP); j++)
                for (int i = 0; i < int'(STEP); i++) begin
                    p = fr[int'(Y0) + row * int'(STEP) + j][int'(X0) + col * int'(STEP) + i];
                    s += int'(p[(2 - ch) * 8 +: 8]);
                end
            r[(2 - ch) * 8 +: 8] = 8'(s / int'(STEP * STEP));
        end
        return r;
    endfunction

    task automatic start_cap(input bit mode);
        START = 1'b1;
        MODE  = mode;
        tick();
        START = 1'b0;
        check("busy_after_start", 32'(BUSY), 32'd1);
        check("done_cleared_by_start", 32'(DONE), 32'd0);
    endtask

    // Raster the frame; optional random idle cycles with coordinates held
    task automatic stream(input bit gaps, input int stop_x, input int stop_y, input bit chk_done);
        for (int y = 0; y < FH; y++) begin
            for (int x = 0; x < FW; x++) begin
                if (gaps) begin
                    while ($urandom_range(99) < 30) begin
                        PIX_VALID = 1'b0;
                        tick();
                    end
                end
                PIX_VALID = 1'b1;
                X_CONT    = CW'(x);
                Y_CONT    = CW'(y);
                PIX_DATA  = fr[y][x];
                tick();
                if (chk_done && y == Y_LAST && x == X_LAST - 1)
                    check("done_before_last_pixel", 32'(DONE), 32'd0);
                if (chk_done && y == Y_LAST && x == X_LAST)
                    check("done_after_last_pixel", 32'(DONE), 32'd1);
                if (x == stop_x && y == stop_y) begin
                    PIX_VALID = 1'b0;
                    return;
                end
            end
        end
        PIX_VALID = 1'b0;
    endtask

    task automatic do_read(input int a, output logic [23:0] d, output logic v);
        RD_EN   = 1'b1;
        RD_ADDR = AW'(a);
        tick();
        RD_EN = 1'b0;
        d = RD_DATA;
        v = RD_VALID;
    endtask

    task automatic read_all(input string tag, input bit avg);
        for (int a = 0; a < int'(OW * OH); a++) begin
            do_read(a, rd_d, rd_v);
            check($sformatf("%s_valid_%0d", tag, a), 32'(rd_v), 32'd1);
            check($sformatf("%s_data_%0d", tag, a), 32'(rd_d), 32'(model(a, avg)));
        end
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; MODE = 1'b0; PIX_VALID = 1'b0;
        X_CONT = '0; Y_CONT = '0; PIX_DATA = '0; RD_EN = 1'b0; RD_ADDR = '0;
        tick();
        tick();
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_rd_valid", 32'(RD_VALID), 32'd0);
        check("rst_rd_data", 32'(RD_DATA), 32'd0);
        RST_N = 1'b1;
        tick();

        // Decimate on the coordinate pattern frame
        fill_pattern();
        start_cap(1'b0);
        stream(1'b0, -1, -1, 1'b1);
        check("dec_busy_end", 32'(BUSY), 32'd0);
        do_read(5, rd_d, rd_v);
        check("dec_addr5", 32'(rd_d), 32'h0c0814);
        do_read(11, rd_d, rd_v);
        check("dec_addr11", 32'(rd_d), 32'h140c20);
        read_all("dec", 1'b0);

        // Box average on the same frame
        start_cap(1'b1);
        stream(1'b0, -1, -1, 1'b1);
        do_read(5, rd_d, rd_v);
        check("avg_addr5", 32'(rd_d), 32'h0d0917);
        do_read(0, rd_d, rd_v);
        check("avg_addr0", 32'(rd_d), 32'h09050f);
        read_all("avg", 1'b1);

        // Read latency and out-of-range address
        tick();
        check("rd_idle_valid", 32'(RD_VALID), 32'd0);
        RD_EN = 1'b1;
        RD_ADDR = '0;
        #1;
        check("rd_not_early", 32'(RD_VALID), 32'd0);
        tick();
        RD_EN = 1'b0;
        check("rd_valid_next", 32'(RD_VALID), 32'd1);
        check("rd_data_next", 32'(RD_DATA), 32'h09050f);
        tick();
        check("rd_valid_drop", 32'(RD_VALID), 32'd0);
        do_read(12, rd_d, rd_v);
        check("rd_oor_valid", 32'(rd_v), 32'd1);
        check("rd_oor_data", 32'(rd_d), 32'd0);

        // Abort a decimate capture and restart in average mode
        start_cap(1'b0);
        done_rises = 0;
        stream(1'b0, 10, 9, 1'b0);
        check("abort_no_done", 32'(DONE), 32'd0);
        start_cap(1'b1);
        stream(1'b0, -1, -1, 1'b1);
        check("abort_done_once", 32'(done_rises), 32'd1);
        read_all("abort", 1'b1);

        // Reset mid-capture, then a frame with no START
        start_cap(1'b0);
        stream(1'b0, 15, 6, 1'b0);
        check("pre_rst_busy", 32'(BUSY), 32'd1);
        RST_N = 1'b0;
        #1;
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_done", 32'(DONE), 32'd0);
        check("mid_rst_rd_valid", 32'(RD_VALID), 32'd0);
        check("mid_rst_rd_data", 32'(RD_DATA), 32'd0);
        tick();
        RST_N = 1'b1;
        tick();
        done_rises = 0;
        stream(1'b0, -1, -1, 1'b0);
        check("nostart_done", 32'(DONE), 32'd0);
        check("nostart_busy", 32'(BUSY), 32'd0);
        check("nostart_no_rise", 32'(done_rises), 32'd0);

        // Average with random valid gaps
        fill_pattern();
        start_cap(1'b1);
        stream(1'b1, -1, -1, 1'b1);
        read_all("gap_avg", 1'b1);

        // Random pixel data in both modes, with gaps
        fill_random();
        start_cap(1'b1);
        stream(1'b1, -1, -1, 1'b1);
        read_all("rnd_avg", 1'b1);
        fill_random();
        start_cap(1'b0);
        stream(1'b1, -1, -1, 1'b1);
        read_all("rnd_dec", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
